// File: rtl/prf_free_list_pkg.sv
// Shared types and constants for the physical-register free list.
// Optional feature macro: FREE_LIST_DUP_CHK_EN.
package is_pkg;

  localparam int PRG_NUM       = 64;
  localparam int PRG_IDX_BITS  = 6;
  localparam int PRG_SIG_WIDTH = 7;
  localparam int ARCH_REG_NUM  = 16;
  localparam int PORT_NUM      = 4;

  typedef logic [PRG_IDX_BITS-1:0] idx_t;
  typedef logic [PRG_IDX_BITS:0]   cnt_t;

  typedef struct packed {
    logic vld;
    idx_t idx;
  } prg_sig_t;

  function automatic logic [2:0] popcount4(input logic [3:0] m);
    popcount4 = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

endpackage

// File: rtl/prf_free_list_if.sv
// Alloc/free port bundle between issue, allocation and the free list.
// Optional feature macro: FREE_LIST_DUP_CHK_EN.
interface prf_free_list_if;
  import is_pkg::*;

  logic [PORT_NUM*PRG_SIG_WIDTH-1:0] fre_prg_frm_is;
  logic [PORT_NUM-1:0]               alc_req_frm_al;
  logic [PORT_NUM*PRG_SIG_WIDTH-1:0] alc_prg_to_al;
  logic                              stl_to_al;

  modport master (
    output fre_prg_frm_is,
    output alc_req_frm_al,
    input  alc_prg_to_al,
    input  stl_to_al
  );

  modport slave (
    input  fre_prg_frm_is,
    input  alc_req_frm_al,
    output alc_prg_to_al,
    output stl_to_al
  );

endinterface

// File: rtl/prf_free_list_prefix_cnt.sv
// Exclusive prefix counts of a 4-bit mask, used to compact port slots.
// Optional feature macro: FREE_LIST_DUP_CHK_EN.
module fl_prefix_cnt
  import is_pkg::*;
(
  input  logic [3:0]      mask,
  output logic [3:0][1:0] pre,
  output logic [2:0]      total
);

  assign pre[0] = 2'd0;
  assign pre[1] = 2'(mask[0]);
  assign pre[2] = 2'(mask[0]) + 2'(mask[1]);
  assign pre[3] = 2'(mask[0]) + 2'(mask[1]) + 2'(mask[2]);
  assign total  = popcount4(mask);

endmodule

// File: rtl/prf_free_list.sv
// Circular free list of physical registers, 4 grants + 4 frees per cycle.
// Optional feature macro: FREE_LIST_DUP_CHK_EN (in-list duplicate filter).
module prf_free_list
  import is_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  prf_free_list_if.slave  bus,
  output cnt_t            fre_cnt,
  output logic            fl_err
);

  idx_t mem [PRG_NUM];
  cnt_t hd_ptr;
  cnt_t tl_ptr;

  prg_sig_t [3:0] fre_sig;
  prg_sig_t [3:0] alc_sig;
  logic [3:0]      req;
  logic [3:0][1:0] gpre;
  logic [3:0][1:0] fpre;
  logic [2:0]      n_req;
  logic [2:0]      n_fre;
  logic [2:0]      n_grant;
  logic [2:0]      n_put;
  logic [3:0]      fre_ok;
  logic [3:0]      dup_drop;
  logic            stall;
  logic [7:0]      sum;
  logic            ovf;
  cnt_t            cnt_nxt;

  assign fre_sig = bus.fre_prg_frm_is;
  assign req     = bus.alc_req_frm_al;

  fl_prefix_cnt u_gnt_cnt (
    .mask  (req),
    .pre   (gpre),
    .total (n_req)
  );

  fl_prefix_cnt u_fre_cnt (
    .mask  (fre_ok),
    .pre   (fpre),
    .total (n_fre)
  );

  // Grant is judged on the registered count only; no free bypass.
  assign stall   = cnt_t'(n_req) > fre_cnt;
  assign n_grant = stall ? 3'd0 : n_req;

  always_comb begin
    alc_sig = '0;
    for (int i = 0; i < 4; i++) begin
      if (!stall && req[i]) begin
        alc_sig[i].vld = 1'b1;
        alc_sig[i].idx = mem[idx_t'(hd_ptr + cnt_t'(gpre[i]))];
      end
    end
  end

  assign bus.alc_prg_to_al = alc_sig;
  assign bus.stl_to_al     = stall;

`ifdef FREE_LIST_DUP_CHK_EN
  logic [PRG_NUM-1:0] in_list;

  always_comb begin
    fre_ok   = '0;
    dup_drop = '0;
    for (int i = 0; i < 4; i++) begin
      fre_ok[i] = fre_sig[i].vld && !in_list[fre_sig[i].idx];
      for (int j = 0; j < i; j++) begin
        if (fre_sig[j].vld && fre_sig[j].idx == fre_sig[i].idx)
          fre_ok[i] = 1'b0;
      end
      dup_drop[i] = fre_sig[i].vld && !fre_ok[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_list <= {{(PRG_NUM-ARCH_REG_NUM){1'b1}}, {ARCH_REG_NUM{1'b0}}};
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (alc_sig[i].vld)
          in_list[alc_sig[i].idx] <= 1'b0;
        if (!ovf && fre_ok[i])
          in_list[fre_sig[i].idx] <= 1'b1;
      end
    end
  end
`else
  always_comb begin
    fre_ok   = '0;
    dup_drop = '0;
    for (int i = 0; i < 4; i++)
      fre_ok[i] = fre_sig[i].vld;
  end
`endif

  // Overflow drops the whole free batch; the grant is unaffected.
  assign sum     = 8'(fre_cnt) - 8'(n_grant) + 8'(n_fre);
  assign ovf     = sum > 8'(PRG_NUM);
  assign n_put   = ovf ? 3'd0 : n_fre;
  assign cnt_nxt = ovf ? (fre_cnt - cnt_t'(n_grant)) : sum[PRG_IDX_BITS:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      hd_ptr  <= '0;
      tl_ptr  <= cnt_t'(PRG_NUM - ARCH_REG_NUM);
      fre_cnt <= cnt_t'(PRG_NUM - ARCH_REG_NUM);
      fl_err  <= 1'b0;
      for (int k = 0; k < PRG_NUM; k++)
        mem[k] <= idx_t'(k + ARCH_REG_NUM);
    end else begin
      hd_ptr  <= hd_ptr + cnt_t'(n_grant);
      tl_ptr  <= tl_ptr + cnt_t'(n_put);
      fre_cnt <= cnt_nxt;
      fl_err  <= fl_err | ovf | (|dup_drop);
      if (!ovf) begin
        for (int i = 0; i < 4; i++) begin
          if (fre_ok[i])
            mem[idx_t'(tl_ptr + cnt_t'(fpre[i]))] <= fre_sig[i].idx;
        end
      end
    end
  end

endmodule
